// File: rtl/not_a_dino_game_ctrl_pkg.sv
// Shared encodings and widths for the dinosaur-runner game controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package not_a_dino_pkg;

  localparam int DIGIT_W  = 4;
  localparam int SCORE_W  = 16;
  localparam int N_DIGITS = SCORE_W / DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

endpackage

// File: rtl/not_a_dino_game_ctrl_if.sv
// Bundle between sync generator / renderer / button and the game controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
// master: drives frame_start, pix_valid, dino_px, obst_px, btn; sees game outputs.
// slave : the controller; drives state, run_en, jump_req, flash, score, hi_score.
interface not_a_dino_game_ctrl_if;
  import not_a_dino_pkg::*;

  logic               frame_start;
  logic               pix_valid;
  logic               dino_px;
  logic               obst_px;
  logic               btn;
  logic [1:0]         state;
  logic               run_en;
  logic               jump_req;
  logic               flash;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hi_score;

  modport master (
    output frame_start, pix_valid, dino_px, obst_px, btn,
    input  state, run_en, jump_req, flash, score, hi_score
  );

  modport slave (
    input  frame_start, pix_valid, dino_px, obst_px, btn,
    output state, run_en, jump_req, flash, score, hi_score
  );
endinterface

// File: rtl/bcd_digit.sv
// One decimal score digit; counts 0..9 and wraps on inc.
// Latency: q updates one cycle after inc/clr.
// Backpressure: none. Ports: clk, rst_n, inc, clr -> q[3:0], carry.
module bcd_digit
  import not_a_dino_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  // carry flags a digit sitting at 9: an increment here ripples upward.
  // Keeping it independent of inc lets the top detect 9999 without a loop.
  assign carry = (q == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/not_a_dino_game_ctrl.sv
// Game controller: button sync, per-frame collision latch, IDLE/RUN/HIT/OVER FSM, BCD score.
// Latency: outputs are registered; state changes one cycle after the triggering event.
// Backpressure: none. Ports: clk, rst_n (sync, active-low), bus (slave modport of the game bundle).
module not_a_dino_game_ctrl
  import not_a_dino_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 8,
  parameter int HIT_FRAMES       = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  not_a_dino_game_ctrl_if.slave bus
);

  localparam logic [7:0] FDIV_LAST = 8'(FRAMES_PER_POINT - 1);
  localparam logic [7:0] HIT_LAST  = 8'(HIT_FRAMES - 1);

  // ---------------- button synchronizer and edge detect ----------------
  logic       btn_s1, btn_s2, btn_s3;
  logic [1:0] sync_vld;
  logic       btn_armed;
  logic       btn_rise;

  // btn_armed only sets once a real (post-reset) low has been seen, so a
  // button held through reset cannot masquerade as a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_s3    <= 1'b0;
      sync_vld  <= 2'b00;
      btn_armed <= 1'b0;
    end else begin
      btn_s1    <= bus.btn;
      btn_s2    <= btn_s1;
      btn_s3    <= btn_s2;
      sync_vld  <= {sync_vld[0], 1'b1};
      btn_armed <= btn_armed | (sync_vld[1] & ~btn_s2);
    end
  end

  assign btn_rise = btn_armed & btn_s2 & ~btn_s3;

  // ---------------- collision accumulator ----------------
  logic coll_acc;
  logic pix_hit;

  assign pix_hit = bus.pix_valid & bus.dino_px & bus.obst_px;

  // The FSM reads coll_acc on frame_start before it restarts; an overlap on
  // that same cycle seeds the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n)               coll_acc <= 1'b0;
    else if (bus.frame_start) coll_acc <= pix_hit;
    else                      coll_acc <= coll_acc | pix_hit;
  end

  // ---------------- FSM ----------------
  game_state_t        state;
  logic               run_en, jump_req, flash;
  logic [7:0]         frame_div, hit_cnt, hit_nxt;
  logic [SCORE_W-1:0] hi_score;
  logic [SCORE_W-1:0] score;
  logic               score_inc, score_clr, score_sat;

  assign hit_nxt = hit_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run_en    <= 1'b0;
      jump_req  <= 1'b0;
      flash     <= 1'b0;
      frame_div <= '0;
      hit_cnt   <= '0;
      hi_score  <= '0;
    end else begin
      jump_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_rise) begin
            state     <= ST_RUN;
            run_en    <= 1'b1;
            frame_div <= '0;
          end
        end
        ST_RUN: begin
          if (bus.frame_start && coll_acc) begin
            // Collision wins over any simultaneous jump press.
            state   <= ST_HIT;
            run_en  <= 1'b0;
            hit_cnt <= '0;
            flash   <= 1'b0;
          end else begin
            jump_req <= btn_rise;
            if (bus.frame_start)
              frame_div <= (frame_div == FDIV_LAST) ? 8'd0 : frame_div + 8'd1;
          end
        end
        ST_HIT: begin
          if (bus.frame_start) begin
            if (hit_cnt == HIT_LAST) begin
              state <= ST_OVER;
              flash <= 1'b0;
              // Packed BCD orders the same as binary, so a plain compare works.
              if (score > hi_score) hi_score <= score;
            end else begin
              hit_cnt <= hit_nxt;
              flash   <= hit_nxt[2];
            end
          end
        end
        ST_OVER: begin
          if (btn_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- BCD score chain ----------------
  logic [N_DIGITS-1:0] dig_inc, dig_nine;

  assign score_sat = &dig_nine;
  assign score_clr = (state == ST_IDLE) & btn_rise;
  assign score_inc = (state == ST_RUN) & bus.frame_start & ~coll_acc &
                     (frame_div == FDIV_LAST) & ~score_sat;

  always_comb begin
    dig_inc    = '0;
    dig_inc[0] = score_inc;
    for (int i = 1; i < N_DIGITS; i++) dig_inc[i] = dig_inc[i-1] & dig_nine[i-1];
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (dig_inc[g]),
      .clr   (score_clr),
      .q     (score[g*DIGIT_W +: DIGIT_W]),
      .carry (dig_nine[g])
    );
  end

  assign bus.state    = state;
  assign bus.run_en   = run_en;
  assign bus.jump_req = jump_req;
  assign bus.flash    = flash;
  assign bus.score    = score;
  assign bus.hi_score = hi_score;

endmodule

// File: tb/tb_not_a_dino_game_ctrl.sv
// Directed bench for the game controller: one default-parameter instance for
// gameplay, one FRAMES_PER_POINT=1 instance for BCD carry and saturation.
module tb_not_a_dino_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  not_a_dino_game_ctrl_if a_if ();
  not_a_dino_game_ctrl_if b_if ();

  not_a_dino_game_ctrl #(.FRAMES_PER_POINT(8), .HIT_FRAMES(60)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );
  not_a_dino_game_ctrl #(.FRAMES_PER_POINT(1), .HIT_FRAMES(60)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   j;

  task automatic push(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got %h want queued entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One frame on instance a: frame_start pulse, then len-1 lit cycles.
  task automatic frame_a(input int len, input bit ovl);
    a_if.frame_start = 1'b1;
    tick();
    a_if.frame_start = 1'b0;
    for (int i = 1; i < len; i++) begin
      a_if.pix_valid = 1'b1;
      a_if.dino_px   = 1'b1;
      a_if.obst_px   = ovl && (i == len / 2);
      tick();
    end
    a_if.pix_valid = 1'b0;
    a_if.dino_px   = 1'b0;
    a_if.obst_px   = 1'b0;
  endtask

  task automatic frames_a(input int n);
    for (int i = 0; i < n; i++) frame_a(4, 1'b0);
  endtask

  task automatic fs_pulse_a();
    a_if.frame_start = 1'b1;
    tick();
    a_if.frame_start = 1'b0;
  endtask

  // 3-cycle press then release; returns number of jump_req cycles seen.
  task automatic press_a(output int jumps);
    jumps = 0;
    a_if.btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_if.jump_req) jumps++;
    end
    a_if.btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_if.jump_req) jumps++;
    end
  endtask

  task automatic press_b();
    b_if.btn = 1'b1;
    idle(3);
    b_if.btn = 1'b0;
    idle(6);
  endtask

  task automatic frames_b(input int n);
    for (int i = 0; i < n; i++) begin
      b_if.frame_start = 1'b1;
      tick();
      b_if.frame_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    a_if.frame_start = 1'b0; a_if.pix_valid = 1'b0; a_if.dino_px = 1'b0;
    a_if.obst_px = 1'b0;     a_if.btn = 1'b0;
    b_if.frame_start = 1'b0; b_if.pix_valid = 1'b0; b_if.dino_px = 1'b0;
    b_if.obst_px = 1'b0;     b_if.btn = 1'b0;
    rst_n = 1'b0;
    idle(3);

    // Reset state
    push("rst_state", 16'h0); push("rst_score", 16'h0); push("rst_hi", 16'h0);
    push("rst_run_en", 16'h0); push("rst_flash", 16'h0); push("rst_jump", 16'h0);
    check(16'(a_if.state)); check(a_if.score); check(a_if.hi_score);
    check(16'(a_if.run_en)); check(16'(a_if.flash)); check(16'(a_if.jump_req));
    rst_n = 1'b1;
    idle(5);

    // Game 1: start, jumps, scoring, collision, HIT countdown
    push("g1_start_jumps", 16'h0); push("g1_state_run", 16'h1); push("g1_run_en", 16'h1);
    press_a(j);
    check(16'(j)); check(16'(a_if.state)); check(16'(a_if.run_en));
    push("jump_first", 16'h1);
    press_a(j);
    check(16'(j));
    push("jump_second", 16'h1);
    press_a(j);
    check(16'(j));

    push("score_16fr", 16'h0002); push("state_16fr", 16'h1);
    frames_a(16);
    check(a_if.score); check(16'(a_if.state));
    push("score_24fr", 16'h0003);
    frames_a(8);
    check(a_if.score);

    push("pre_hit_state", 16'h1);
    frame_a(4, 1'b1);
    check(16'(a_if.state));
    push("hit_state", 16'h2); push("hit_run_en", 16'h0); push("hit_score", 16'h0003);
    push("hit_jump", 16'h0); push("hit_flash0", 16'h0);
    fs_pulse_a();
    check(16'(a_if.state)); check(16'(a_if.run_en)); check(a_if.score);
    check(16'(a_if.jump_req)); check(16'(a_if.flash));

    push("flash_cnt4", 16'h1);
    frames_a(4);
    check(16'(a_if.flash));
    push("flash_cnt8", 16'h0);
    frames_a(4);
    check(16'(a_if.flash));
    push("hit_59fr", 16'h2);
    frames_a(51);
    check(16'(a_if.state));
    push("over_state", 16'h3); push("over_hi", 16'h0003); push("over_flash", 16'h0);
    push("over_score", 16'h0003); push("over_run_en", 16'h0);
    frames_a(1);
    check(16'(a_if.state)); check(a_if.hi_score); check(16'(a_if.flash));
    check(a_if.score); check(16'(a_if.run_en));

    // Game 2: ends at 5, beats 3
    push("over_to_idle", 16'h0); push("idle_score_held", 16'h0003);
    press_a(j);
    check(16'(a_if.state)); check(a_if.score);
    push("g2_run", 16'h1); push("g2_score_clr", 16'h0);
    press_a(j);
    check(16'(a_if.state)); check(a_if.score);
    push("g2_score", 16'h0005);
    frames_a(40);
    check(a_if.score);
    push("g2_hit", 16'h2);
    frame_a(4, 1'b1);
    fs_pulse_a();
    check(16'(a_if.state));
    push("g2_over", 16'h3); push("g2_hi", 16'h0005);
    frames_a(60);
    check(16'(a_if.state)); check(a_if.hi_score);

    // Game 3: ends at 2, hi_score must stay 5
    press_a(j);
    press_a(j);
    frames_a(16);
    frame_a(4, 1'b1);
    fs_pulse_a();
    push("g3_over", 16'h3); push("g3_hi_kept", 16'h0005); push("g3_score", 16'h0002);
    frames_a(60);
    check(16'(a_if.state)); check(a_if.hi_score); check(a_if.score);

    // Game 4: reset while in HIT, button held through reset
    press_a(j);
    press_a(j);
    frames_a(8);
    frame_a(4, 1'b1);
    fs_pulse_a();
    push("g4_hit", 16'h2); push("g4_flash", 16'h1);
    frames_a(4);
    check(16'(a_if.state)); check(16'(a_if.flash));
    rst_n    = 1'b0;
    a_if.btn = 1'b1;
    push("rst_hit_state", 16'h0); push("rst_hit_flash", 16'h0); push("rst_hit_hi", 16'h0);
    tick();
    check(16'(a_if.state)); check(16'(a_if.flash)); check(a_if.hi_score);
    idle(2);
    rst_n = 1'b1;
    push("held_btn_idle", 16'h0);
    idle(10);
    check(16'(a_if.state));
    a_if.btn = 1'b0;
    idle(5);
    push("repress_run", 16'h1);
    press_a(j);
    check(16'(a_if.state));

    // Instance b: BCD carries and saturation
    push("b_run", 16'h1);
    press_b();
    check(16'(b_if.state));
    push("b_0009", 16'h0009);
    frames_b(9);
    check(b_if.score);
    push("b_0010", 16'h0010);
    frames_b(1);
    check(b_if.score);
    push("b_0999", 16'h0999);
    frames_b(989);
    check(b_if.score);
    push("b_1000", 16'h1000);
    frames_b(1);
    check(b_if.score);
    push("b_9999", 16'h9999);
    frames_b(8999);
    check(b_if.score);
    push("b_sat", 16'h9999); push("b_sat_state", 16'h1);
    frames_b(3);
    check(b_if.score); check(16'(b_if.state));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
